// File: rtl/lab2_nios2_gen2_0_cpu_debug_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lab2_nios2_gen2_0_cpu_debug_host_pkg
// Description : Shared state encoding and default widths for the virtual-JTAG
//               debug host and its tck divider.
// Revision    : 1.0  initial release
// ============================================================================
package lab2_nios2_gen2_0_cpu_debug_host_pkg;

    // Default scan geometry of the Nios II debug slave
    localparam int DEF_DR_WIDTH = 38;
    localparam int DEF_IR_WIDTH = 2;

    // Scan sequencer states, in the order they are visited
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5,
        ST_DONE = 3'd6
    } state_e;

    // tck only runs while a scan is in flight
    function automatic logic state_is_active(input state_e s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lab2_nios2_gen2_0_cpu_debug_host_tckgen.sv
`default_nettype none
// ============================================================================
// Module      : lab2_nios2_gen2_0_cpu_debug_host_tckgen
// Description : Divides clk down to the virtual-JTAG tck and flags the clk
//               cycle whose closing edge makes tck rise or fall.
// Revision    : 1.0  initial release
// ============================================================================
module lab2_nios2_gen2_0_cpu_debug_host_tckgen #(
    parameter int TCK_HALF = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int            CW   = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(TCK_HALF - 1);

    logic [CW-1:0] cnt_d, cnt_q;
    logic          tck_d, tck_q;
    logic          at_last;

    // Half-period counter; tck is parked low whenever the divider is idle
    always_comb begin
        at_last = (cnt_q == LAST);
        cnt_d   = cnt_q;
        tck_d   = tck_q;
        if (clear || !enable) begin
            cnt_d = '0;
            tck_d = 1'b0;
        end else if (at_last) begin
            cnt_d = '0;
            tck_d = !tck_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        rise = enable && !clear && at_last && !tck_q;
        fall = enable && !clear && at_last &&  tck_q;
    end

    // Divider state registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

    assign tck = tck_q;

endmodule
`default_nettype wire

// File: rtl/lab2_nios2_gen2_0_cpu_debug_host.sv
`default_nettype none
// ============================================================================
// Module      : lab2_nios2_gen2_0_cpu_debug_host
// Description : Drives one complete virtual-JTAG scan (UIR, CDR, SDR, UDR,
//               RTI) into the Nios II debug slave per accepted command and
//               returns the captured DR bits and IR status.
// Revision    : 1.0  initial release
// ============================================================================
module lab2_nios2_gen2_0_cpu_debug_host
    import lab2_nios2_gen2_0_cpu_debug_host_pkg::*;
#(
    parameter int DR_WIDTH = DEF_DR_WIDTH,
    parameter int IR_WIDTH = DEF_IR_WIDTH,
    parameter int TCK_HALF = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir,
    output logic                vji_tck,
    output logic                vji_tdi,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic                vji_tdo,
    input  logic [IR_WIDTH-1:0] vji_ir_out
);

    localparam int            BW       = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DR_WIDTH - 1);

    state_e              state_d, state_q;
    logic [IR_WIDTH-1:0] ir_d, ir_q;
    logic [IR_WIDTH-1:0] ir_cap_d, ir_cap_q;
    logic [DR_WIDTH-1:0] shift_d, shift_q;
    logic [BW-1:0]       bit_d, bit_q;
    logic                rdy_d, rdy_q;

    logic                accept;
    logic                scan_active;
    logic                tck_rise;
    logic                tck_fall;
    logic [DR_WIDTH-1:0] shift_in;

    assign scan_active = state_is_active(state_q);
    assign accept      = cmd_valid && cmd_ready;

    lab2_nios2_gen2_0_cpu_debug_host_tckgen #(
        .TCK_HALF (TCK_HALF)
    ) u_tckgen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (scan_active),
        .clear   (accept),
        .tck     (vji_tck),
        .rise    (tck_rise),
        .fall    (tck_fall)
    );

    // Captured tdo enters at the MSB so the first bit shifted out lands at the LSB
    generate
        if (DR_WIDTH > 1) begin : g_shift_wide
            assign shift_in = {vji_tdo, shift_q[DR_WIDTH-1:1]};
        end else begin : g_shift_one
            assign shift_in = vji_tdo;
        end
    endgenerate

    // Scan sequencer: every scan-phase exit waits for a tck fall so strobes never move under a rising tck
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        ir_cap_d = ir_cap_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        rdy_d    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ir_d    = cmd_ir;
                    shift_d = cmd_data;
                    state_d = ST_UIR;
                end
            end
            ST_UIR: begin
                if (tck_rise) ir_cap_d = vji_ir_out;
                if (tck_fall) state_d  = ST_CDR;
            end
            ST_CDR: begin
                if (tck_fall) begin
                    bit_d   = '0;
                    state_d = ST_SDR;
                end
            end
            ST_SDR: begin
                if (tck_rise) shift_d = shift_in;
                if (tck_fall) begin
                    if (bit_q == LAST_BIT) state_d = ST_UDR;
                    else                   bit_d   = bit_q + BW'(1);
                end
            end
            ST_UDR: begin
                if (tck_fall) state_d = ST_RTI;
            end
            ST_RTI: begin
                if (tck_fall) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; rdy_q holds cmd_ready off until the cycle after reset releases
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            ir_q     <= '0;
            ir_cap_q <= '0;
            shift_q  <= '0;
            bit_q    <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            ir_cap_q <= ir_cap_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            rdy_q    <= rdy_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE) && rdy_q;
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_data  = shift_q;
    assign rsp_ir    = ir_cap_q;

    assign vji_uir   = (state_q == ST_UIR);
    assign vji_cdr   = (state_q == ST_CDR);
    assign vji_sdr   = (state_q == ST_SDR);
    assign vji_udr   = (state_q == ST_UDR);
    assign vji_rti   = (state_q == ST_RTI);
    assign vji_tdi   = vji_sdr && shift_q[0];
    assign vji_ir_in = scan_active ? ir_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_lab2_nios2_gen2_0_cpu_debug_host.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lab2_nios2_gen2_0_cpu_debug_host
// Description : Self-checking bench for the virtual-JTAG debug host.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lab2_nios2_gen2_0_cpu_debug_host;

    localparam int DR       = 38;
    localparam int IR       = 2;
    localparam int LAT_MAIN = 1 + (DR + 4) * 2 * 2;
    localparam int LAT_FAST = 1 + (DR + 4) * 2 * 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic          cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0;
    logic [IR-1:0] cmd_ir = '0, rsp_ir, vji_ir_in, vji_ir_out = '0;
    logic [DR-1:0] cmd_data = '0, rsp_data;
    logic          vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdo;

    // TCK_HALF=1 instance for back-to-back commands
    logic          f_cmd_valid = 1'b0, f_cmd_ready, f_rsp_valid, f_rsp_ready = 1'b0;
    logic [IR-1:0] f_rsp_ir, f_vji_ir_in;
    logic [DR-1:0] f_rsp_data;
    logic          f_tck, f_tdi, f_uir, f_cdr, f_sdr, f_udr, f_rti;

    lab2_nios2_gen2_0_cpu_debug_host u_dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ir(rsp_ir),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_uir(vji_uir), .vji_cdr(vji_cdr),
        .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti), .vji_ir_in(vji_ir_in),
        .vji_tdo(vji_tdo), .vji_ir_out(vji_ir_out)
    );

    lab2_nios2_gen2_0_cpu_debug_host #(.TCK_HALF(1)) u_fast (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready), .cmd_ir(2'b11), .cmd_data(38'h15_5555_5555),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_data(f_rsp_data), .rsp_ir(f_rsp_ir),
        .vji_tck(f_tck), .vji_tdi(f_tdi), .vji_uir(f_uir), .vji_cdr(f_cdr),
        .vji_sdr(f_sdr), .vji_udr(f_udr), .vji_rti(f_rti), .vji_ir_in(f_vji_ir_in),
        .vji_tdo(1'b1), .vji_ir_out(2'b01)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected responses, pushed at accept and popped at rsp_valid
    typedef struct {
        logic [DR-1:0] data;
        logic [IR-1:0] ir;
        int            acc;
    } sb_t;
    sb_t sb[$];

    // Slave model: tdo_mode 0 = tied low, 1 = tied high, 2 = tdi looped back one tck later
    int   tdo_mode = 0;
    logic lb_low = 1'b0;
    logic lb_q   = 1'b0;
    assign vji_tdo = (tdo_mode == 2) ? lb_q : (tdo_mode == 1);

    logic          prev_tck  = 1'b0;
    logic          prev_sdr  = 1'b0;
    logic [4:0]    prev_strb = '0;
    logic          rst_edge  = 1'b0;
    int            sdr_rises = 0;
    logic          tdi_sdr_low = 1'b0;
    logic [DR-1:0] tdi_bits = '0;
    int            tdi_idx = 0;

    always @(posedge clk) rst_edge <= !reset_n;

    // Protocol monitor and loopback slave on the default instance
    always @(negedge clk) begin
        logic [4:0] strb;
        strb = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
        chk("strobe_onehot0", 64'($onehot0(strb)), 64'(1));
        if (!rst_edge && prev_strb != 5'd0 && strb != prev_strb)
            chk("strobe_edge_on_fall", 64'({prev_tck, vji_tck}), 64'(2'b10));
        if (vji_sdr && !prev_sdr) begin
            sdr_rises = 0;
            tdi_idx   = 0;
        end
        if (vji_sdr && !vji_tck) tdi_sdr_low = vji_tdi;
        if (vji_sdr && vji_tck && !prev_tck) begin
            if (tdi_idx < DR) tdi_bits[tdi_idx] = tdi_sdr_low;
            tdi_idx++;
            sdr_rises++;
        end
        if (prev_sdr && !vji_sdr && !rst_edge)
            chk("sdr_rise_count", 64'(sdr_rises), 64'(DR));
        if (!vji_tck) lb_low = vji_tdi;
        if (vji_tck && !prev_tck) lb_q = lb_low;
        prev_tck  = vji_tck;
        prev_sdr  = vji_sdr;
        prev_strb = strb;
    end

    task automatic run_scan(input logic [IR-1:0] ir, input logic [DR-1:0] data,
                            input int mode, input logic [IR-1:0] irout, input int hold);
        sb_t  e;
        int   t;
        logic ok;
        tdo_mode   = mode;
        vji_ir_out = irout;
        cmd_ir     = ir;
        cmd_data   = data;
        cmd_valid  = 1'b1;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", 64'(cmd_ready), 64'(1));
        e.data = (mode == 2) ? {data[DR-2:0], 1'b0} : ((mode == 1) ? '1 : '0);
        e.ir   = irout;
        e.acc  = cyc;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("uir_strobe_ir_in", 64'({vji_uir, vji_ir_in}), 64'({1'b1, ir}));
        t = 0;
        while (rsp_valid !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("rsp_valid_seen", 64'(rsp_valid), 64'(1));
        e = sb.pop_front();
        chk("latency", 64'(cyc - e.acc), 64'(LAT_MAIN));
        chk("rsp_data", 64'(rsp_data), 64'(e.data));
        chk("rsp_ir", 64'(rsp_ir), 64'(e.ir));
        ok = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== e.data || cmd_ready !== 1'b0 ||
                vji_tck !== 1'b0 || vji_ir_in !== '0) ok = 1'b0;
        end
        if (hold > 0) chk("hold_stable", 64'(ok), 64'(1));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("idle_after_handshake", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
    endtask

    initial begin
        logic [DR-1:0] d;
        int            t;
        logic          saw;
        int            facc[2];
        int            frsp[2];
        int            na;
        int            nr;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_vji", 64'({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_ir_in}), 64'(0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(0));
        chk("rst_rsp_ir", 64'(rsp_ir), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(cmd_ready), 64'(1));

        // Loopback scan: tdi must carry cmd_data LSB first
        run_scan(2'b01, 38'h2A_5555_AAAA, 2, 2'b10, 0);
        chk("tdi_bits", 64'(tdi_bits), 64'(38'h2A_5555_AAAA));
        chk("tdi_count", 64'(tdi_idx), 64'(DR));

        // tdo tied high with a long hold on rsp_ready, then tdo tied low
        d = DR'({$urandom(), $urandom()});
        run_scan(2'b11, d, 1, 2'b01, 50);
        d = DR'({$urandom(), $urandom()});
        run_scan(2'b10, d, 0, 2'b11, 0);

        // Reset in the middle of SDR aborts the scan
        tdo_mode  = 2;
        cmd_ir    = 2'b10;
        cmd_data  = DR'({$urandom(), $urandom()});
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (!(vji_sdr === 1'b1 && tdi_idx >= 10) && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("reached_sdr_bit10", 64'(vji_sdr), 64'(1));
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("abort_vji", 64'({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_ir_in}), 64'(0));
        chk("abort_rsp", 64'({rsp_data, rsp_ir}), 64'(0));
        sb.delete();
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_again", 64'(cmd_ready), 64'(1));
        saw = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) saw = 1'b1;
        end
        chk("abort_no_rsp", 64'(saw), 64'(0));

        // Normal scan after the abort
        run_scan(2'b01, 38'h01_2345_6789, 2, 2'b01, 0);
        chk("tdi_bits_after_abort", 64'(tdi_bits), 64'(38'h01_2345_6789));

        // Back-to-back commands on the TCK_HALF=1 instance
        facc[0] = -1000; facc[1] = -1000;
        frsp[0] = -1000; frsp[1] = -1000;
        na = 0;
        nr = 0;
        f_cmd_valid = 1'b1;
        f_rsp_ready = 1'b1;
        t = 0;
        while (nr < 2 && t < 400) begin
            if (f_cmd_valid && f_cmd_ready && na < 2) begin
                facc[na] = cyc;
                na++;
            end
            if (f_rsp_valid && f_rsp_ready && nr < 2) begin
                frsp[nr] = cyc;
                chk("fast_rsp_data", 64'(f_rsp_data), 64'({DR{1'b1}}));
                chk("fast_rsp_ir", 64'(f_rsp_ir), 64'(2'b01));
                nr++;
            end
            @(negedge clk);
            t++;
        end
        f_cmd_valid = 1'b0;
        chk("fast_rsp_count", 64'(nr), 64'(2));
        chk("fast_latency_0", 64'(frsp[0] - facc[0]), 64'(LAT_FAST));
        chk("fast_second_accept", 64'(facc[1] - frsp[0]), 64'(1));
        chk("fast_latency_1", 64'(frsp[1] - facc[1]), 64'(LAT_FAST));
        repeat (100) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
